// File: rtl/register_list_sequencer_pkg.sv
// Shared types for the register-list save/restore sequencer.
package register_list_sequencer_pkg;

  typedef logic [31:0] t_reg;
  typedef logic [3:0]  t_reg_index;

  localparam int unsigned NUM_REGS   = 16;
  localparam t_reg        STACK_STEP = 32'd4;

  typedef enum logic [2:0] {IDLE, DEC, STORE, LOAD, FINISH} t_rls_state;

  function automatic logic [NUM_REGS-1:0] index_onehot(input t_reg_index idx);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/register_list_sequencer_reg_mask_encoder.sv
// Finds the highest or lowest set bit of a register mask, plus an empty flag.
module reg_mask_encoder
  import register_list_sequencer_pkg::*;
(
  input  logic [15:0] i_mask,
  input  logic        i_highest,
  output logic [3:0]  o_index,
  output logic        o_empty
);

  logic [3:0] w_pos;

  // Last match wins, so scan order decides highest versus lowest.
  always_comb begin
    o_index = '0;
    w_pos   = '0;
    for (int k = 0; k < 16; k++) begin
      w_pos = i_highest ? k[3:0] : (4'd15 - k[3:0]);
      if (i_mask[w_pos]) o_index = w_pos;
    end
  end

  assign o_empty = (i_mask == '0);

endmodule

// File: rtl/register_list_sequencer.sv
// Sequences push/pop of a register list between the register file and the memory bus.
module register_list_sequencer
  import register_list_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_push,
  input  logic [15:0] i_reg_mask,
  input  logic [3:0]  i_sp_index,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [3:0]  o_rf_read1_index,
  input  logic [31:0] i_rf_read1_data,
  output logic [3:0]  o_rf_read2_index,
  input  logic [31:0] i_rf_read2_data,
  output logic        o_rf_write,
  output logic [3:0]  o_rf_write_index,
  output logic [31:0] o_rf_write_data,
  output logic        o_rf_inc,
  output logic        o_rf_dec,
  output logic [3:0]  o_rf_incdec_index,
  output logic        o_bus_req,
  output logic        o_bus_write,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_error
);

  t_rls_state  r_state, w_state_next;
  logic        r_push, w_push_next;
  t_reg_index  r_sp_index, w_sp_index_next;
  logic [15:0] r_mask, w_mask_next;
  logic        r_error, w_error_next;
  logic [31:0] r_timeout, w_timeout_next;

  t_reg_index  w_cur_index, w_rem_index;
  logic        w_cur_empty, w_rem_empty;
  logic [15:0] w_start_mask, w_mask_cleared;
  logic        w_in_access, w_ack_ok, w_timed_out, w_rf_write, w_rf_inc;
  logic        w_unused_enc;

  assign w_start_mask   = i_reg_mask & ~index_onehot(i_sp_index);
  assign w_mask_cleared = r_mask & ~index_onehot(w_cur_index);
  assign w_in_access    = (r_state == STORE) || (r_state == LOAD);
  assign w_ack_ok       = i_bus_ack && !i_bus_error;
  assign w_timed_out    = (TIMEOUT_CYCLES != 0) && (r_timeout == TIMEOUT_CYCLES - 1);
  assign w_unused_enc   = ^{w_rem_index, w_cur_empty};

  reg_mask_encoder u_cur_enc (
    .i_mask    (r_mask),
    .i_highest (r_push),
    .o_index   (w_cur_index),
    .o_empty   (w_cur_empty)
  );

  // Tests what is left once the current register retires.
  reg_mask_encoder u_rem_enc (
    .i_mask    (w_mask_cleared),
    .i_highest (r_push),
    .o_index   (w_rem_index),
    .o_empty   (w_rem_empty)
  );

  always_comb begin
    w_state_next    = r_state;
    w_push_next     = r_push;
    w_sp_index_next = r_sp_index;
    w_mask_next     = r_mask;
    w_error_next    = r_error;
    w_rf_write      = 1'b0;
    w_rf_inc        = 1'b0;
    w_timeout_next  = (w_in_access && !i_bus_ack) ? r_timeout + 32'd1 : '0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_push_next     = i_push;
          w_sp_index_next = i_sp_index;
          w_mask_next     = w_start_mask;
          w_error_next    = 1'b0;
          if (w_start_mask == '0) w_state_next = FINISH;
          else                    w_state_next = i_push ? DEC : LOAD;
        end
      end
      DEC: w_state_next = STORE;
      STORE, LOAD: begin
        if (i_bus_ack && i_bus_error) begin
          w_error_next = 1'b1;
          w_state_next = FINISH;
        end else if (w_ack_ok) begin
          w_rf_write   = (r_state == LOAD);
          w_rf_inc     = (r_state == LOAD);
          w_mask_next  = w_mask_cleared;
          if (w_rem_empty)           w_state_next = FINISH;
          else if (r_state == STORE) w_state_next = DEC;
          else                       w_state_next = LOAD;
        end else if (w_timed_out) begin
          w_error_next = 1'b1;
          w_state_next = FINISH;
        end
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_push     <= 1'b0;
      r_sp_index <= '0;
      r_mask     <= '0;
      r_error    <= 1'b0;
      r_timeout  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_push     <= w_push_next;
      r_sp_index <= w_sp_index_next;
      r_mask     <= w_mask_next;
      r_error    <= w_error_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign o_busy            = (r_state == DEC) || w_in_access;
  assign o_done            = (r_state == FINISH);
  assign o_error           = r_error;
  assign o_rf_read1_index  = r_sp_index;
  assign o_rf_read2_index  = w_cur_index;
  assign o_rf_write        = w_rf_write;
  assign o_rf_write_index  = w_cur_index;
  assign o_rf_write_data   = w_rf_write ? i_bus_rdata : '0;
  assign o_rf_inc          = w_rf_inc;
  assign o_rf_dec          = (r_state == DEC);
  assign o_rf_incdec_index = r_sp_index;
  assign o_bus_req         = w_in_access;
  assign o_bus_write       = (r_state == STORE);
  assign o_bus_addr        = w_in_access ? i_rf_read1_data : '0;
  assign o_bus_wdata       = (r_state == STORE) ? i_rf_read2_data : '0;

endmodule

// File: tb/tb_register_list_sequencer.sv
// Bench: register file and memory models around the sequencer, scoreboarded per access.
module tb_register_list_sequencer;
  import register_list_sequencer_pkg::*;

  localparam int unsigned TIMEOUT = 4;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, push = 1'b0;
  logic [15:0] reg_mask = '0;
  logic [3:0]  sp_index = '0;
  logic        busy, done, error, rf_write, rf_inc, rf_dec;
  logic        bus_req, bus_write, bus_ack, bus_error;
  logic [3:0]  rf_read1_index, rf_read2_index, rf_write_index, rf_incdec_index;
  logic [31:0] rf_read1_data, rf_read2_data, rf_write_data;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  register_list_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clock (clock), .i_reset (reset), .i_start (start), .i_push (push),
    .i_reg_mask (reg_mask), .i_sp_index (sp_index),
    .o_busy (busy), .o_done (done), .o_error (error),
    .o_rf_read1_index (rf_read1_index), .i_rf_read1_data (rf_read1_data),
    .o_rf_read2_index (rf_read2_index), .i_rf_read2_data (rf_read2_data),
    .o_rf_write (rf_write), .o_rf_write_index (rf_write_index),
    .o_rf_write_data (rf_write_data), .o_rf_inc (rf_inc), .o_rf_dec (rf_dec),
    .o_rf_incdec_index (rf_incdec_index),
    .o_bus_req (bus_req), .o_bus_write (bus_write), .o_bus_addr (bus_addr),
    .o_bus_wdata (bus_wdata), .i_bus_rdata (bus_rdata), .i_bus_ack (bus_ack),
    .i_bus_error (bus_error)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, req_cycles = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file model
  logic [31:0] rf [16];
  assign rf_read1_data = rf[rf_read1_index];
  assign rf_read2_data = rf[rf_read2_index];
  always @(posedge clock) begin
    if (rf_write) rf[rf_write_index] = rf_write_data;
    if (rf_inc)   rf[rf_incdec_index] = rf[rf_incdec_index] + STACK_STEP;
    if (rf_dec)   rf[rf_incdec_index] = rf[rf_incdec_index] - STACK_STEP;
  end

  // Memory model; unwritten words read back as the inverted address
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  int min_wait = 0, max_wait = 0, err_at = -1, ack_num = 0, cur_wait = 0, wcnt = 0;
  bit never_ack = 0, active = 0;
  initial begin
    bus_ack = 1'b0; bus_error = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (bus_ack) begin
        bus_ack = 1'b0; bus_error = 1'b0; bus_rdata = '0; active = 0;
      end
      if (bus_req && !reset) begin
        if (!active) begin
          active = 1; wcnt = 0;
          cur_wait = int'($urandom_range(max_wait, min_wait));
        end
        if (!never_ack) begin
          if (wcnt == cur_wait) begin
            bus_ack = 1'b1;
            bus_error = (ack_num == err_at);
            ack_num++;
            if (bus_write) begin
              if (!bus_error) mem[bus_addr] = bus_wdata;
            end else bus_rdata = mem_rd(bus_addr);
          end else wcnt++;
        end
      end else active = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  ridx;
    logic        fail;
  } acc_t;
  typedef struct {
    logic err;
    int   lat;
  } fin_t;
  acc_t acc_q[$];
  fin_t fin_q[$];
  acc_t mon_a;
  fin_t mon_f;

  // Monitor: compares each completed access and each done pulse against the queues
  always @(negedge clock) begin
    if (!reset) begin
      if (bus_req) req_cycles++;
      if (bus_req && bus_ack) begin
        check("access_expected", 32'(acc_q.size() > 0), 32'd1);
        if (acc_q.size() > 0) begin
          mon_a = acc_q.pop_front();
          check("acc_addr", bus_addr, mon_a.addr);
          check("acc_write", 32'(bus_write), 32'(mon_a.wr));
          if (mon_a.wr) check("acc_wdata", bus_wdata, mon_a.wdata);
          else begin
            check("rf_write", 32'(rf_write), 32'(!mon_a.fail));
            if (!mon_a.fail) check("rf_write_index", 32'(rf_write_index), 32'(mon_a.ridx));
          end
        end
      end
      if (done) begin
        check("done_expected", 32'(fin_q.size() > 0), 32'd1);
        if (fin_q.size() > 0) begin
          mon_f = fin_q.pop_front();
          check("done_error", 32'(error), 32'(mon_f.err));
          if (mon_f.lat >= 0) check("latency", 32'(cyc - start_cyc), 32'(mon_f.lat));
          check("leftover_accesses", 32'(acc_q.size()), 32'd0);
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, 32'({busy, done, error, bus_req, bus_write, rf_write, rf_inc, rf_dec}),
          32'd0);
    check({tag, "_indices"}, 32'({rf_read1_index, rf_read2_index, rf_write_index,
          rf_incdec_index}), 32'd0);
    check({tag, "_bus"}, bus_addr | bus_wdata | rf_write_data, 32'd0);
  endtask

  // Reference model: walks the list in order and queues the expected accesses
  task automatic run_op(input logic p, input logic [15:0] m, input logic [3:0] sp,
                        input int mw, input int e_at, input bit nack);
    logic [15:0] eff;
    logic [31:0] spv;
    logic [31:0] exp_rf [16];
    logic [31:0] wa [$];
    logic [31:0] wv [$];
    int          lst [$];
    int          nacc;
    bit          got, eflag;
    fin_t        f;
    eff = m & ~(16'h1 << sp);
    for (int r = 0; r < 16; r++) begin
      exp_rf[r] = rf[r];
      if (eff[r]) begin
        if (p) lst.push_front(r);
        else   lst.push_back(r);
      end
    end
    spv = rf[sp]; nacc = 0; eflag = 0;
    for (int k = 0; k < lst.size(); k++) begin
      if (nack) begin
        if (p) spv = spv - STACK_STEP;
        eflag = 1;
        break;
      end
      nacc++;
      if (p) begin
        spv = spv - STACK_STEP;
        acc_q.push_back('{spv, 1'b1, exp_rf[lst[k]], 4'(lst[k]), k == e_at});
        if (k == e_at) begin eflag = 1; break; end
        wa.push_back(spv); wv.push_back(exp_rf[lst[k]]);
      end else begin
        acc_q.push_back('{spv, 1'b0, 32'd0, 4'(lst[k]), k == e_at});
        if (k == e_at) begin eflag = 1; break; end
        exp_rf[lst[k]] = mem_rd(spv);
        spv = spv + STACK_STEP;
      end
    end
    exp_rf[sp] = spv;
    f.err = eflag;
    if (lst.size() == 0)   f.lat = 1;
    else if (nack)         f.lat = p ? int'(TIMEOUT) + 2 : int'(TIMEOUT) + 1;
    else if (mw == 0)      f.lat = p ? 1 + 2 * nacc : 1 + nacc;
    else                   f.lat = -1;
    fin_q.push_back(f);
    min_wait = 0; max_wait = mw; err_at = e_at; never_ack = nack; ack_num = 0;
    req_cycles = 0;
    @(negedge clock);
    start = 1'b1; push = p; reg_mask = m; sp_index = sp; start_cyc = cyc;
    @(negedge clock);
    check("error_cleared_on_start", 32'(error), 32'd0);
    got = 0;
    // Junk starts while busy must be ignored
    for (int t = 0; t < 300; t++) begin
      if (done) begin got = 1; break; end
      start = 1'($urandom); push = 1'($urandom);
      reg_mask = 16'($urandom); sp_index = 4'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    @(negedge clock);
    check("error_sticky", 32'(error), 32'(eflag));
    check("idle_not_busy", 32'(busy | done), 32'd0);
    for (int r = 0; r < 16; r++) check($sformatf("rf_r%0d", r), rf[r], exp_rf[r]);
    for (int i = 0; i < wa.size(); i++) check("mem_word", mem_rd(wa[i]), wv[i]);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = $urandom;
    repeat (2) @(negedge clock);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clock);
    check_quiet("post_reset");

    rf[15] = 32'h100; rf[1] = 32'h11; rf[2] = 32'h22;
    run_op(1'b1, 16'h0006, 4'd15, 0, -1, 0);
    check("push_mem_fc", mem_rd(32'hFC), 32'h22);
    check("push_mem_f8", mem_rd(32'hF8), 32'h11);
    check("push_sp", rf[15], 32'hF8);

    rf[1] = 32'h0; rf[2] = 32'h0;
    run_op(1'b0, 16'h0006, 4'd15, 0, -1, 0);
    check("pop_r1", rf[1], 32'h11);
    check("pop_r2", rf[2], 32'h22);
    check("pop_sp", rf[15], 32'h100);

    run_op(1'b1, 16'h8001, 4'd15, 0, -1, 0);
    check("sp_in_list_one_access", 32'(req_cycles), 32'd1);
    run_op(1'b1, 16'h0000, 4'd3, 0, -1, 0);
    check("empty_no_bus_req", 32'(req_cycles), 32'd0);

    rf[15] = 32'h200; rf[4] = 32'hAAAA; rf[6] = 32'hBBBB;
    run_op(1'b0, 16'h0050, 4'd15, 0, 1, 0);
    check("buserr_sp", rf[15], 32'h204);
    check("buserr_r6_kept", rf[6], 32'hBBBB);
    repeat (3) @(negedge clock);
    check("buserr_error_held", 32'(error), 32'd1);

    rf[15] = 32'h300;
    run_op(1'b1, 16'h0002, 4'd15, 0, -1, 1);
    check("timeout_req_cycles", 32'(req_cycles), TIMEOUT);
    check("timeout_sp", rf[15], 32'h2FC);

    // Reset in the middle of a slow store
    min_wait = 3; max_wait = 3; never_ack = 0; err_at = -1;
    @(negedge clock);
    start = 1'b1; push = 1'b1; reg_mask = 16'h0006; sp_index = 4'd15;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_reset_bus_req", 32'(bus_req), 32'd1);
    #2 reset = 1'b1;
    #1 check_quiet("mid_op_reset");
    @(negedge clock);
    reset = 1'b0;
    acc_q.delete(); fin_q.delete();
    rf[15] = 32'h400;
    run_op(1'b1, 16'h0030, 4'd15, 0, -1, 0);

    for (int n = 0; n < 30; n++) begin
      logic        p;
      logic [3:0]  sp;
      logic [15:0] m;
      int          e_at;
      p  = 1'($urandom);
      sp = 4'($urandom);
      m  = ($urandom_range(0, 3) == 0) ? 16'($urandom) & 16'($urandom) : 16'($urandom);
      e_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (p) rf[sp] = 32'h1000 + 32'($urandom_range(0, 64)) * STACK_STEP;
      run_op(p, m, sp, int'($urandom_range(0, 2)), e_at, $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
